// File: rtl/video_mode_switcher.sv
// rtl/video_mode_switcher.sv - glitch-free video mode change sequencer
// Owns the timing generator's mode index: drain, blank, load, settle, then run.

module video_mode_switcher #(
   parameter int MODE_BITS      = 3,
   parameter int DEFAULT_MODE   = 0,
   parameter int BLANK_FRAMES   = 2,
   parameter int SETTLE_FRAMES  = 4,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   input  logic [MODE_BITS-1:0] req_mode,
   output logic                 req_ready,
   input  logic                 frame_start,
   output logic [MODE_BITS-1:0] mode,
   output logic                 mode_load,
   output logic                 video_enable,
   output logic                 locked,
   output logic                 timeout_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [7:0] BLANK_LAST  = 8'(BLANK_FRAMES - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

   typedef enum logic [2:0] {LOAD, SETTLE, RUN, DRAIN, BLANK} state_t;

   state_t               state;
   logic [MODE_BITS-1:0] pending;
   logic [7:0]           frame_cnt;
   logic [TW-1:0]        tmo_cnt;
   logic                 waiting;
   logic                 tmo_hit;
   logic                 boundary;

   // A timed-out wait behaves exactly like a real frame boundary.
   always_comb begin
      waiting  = (state == SETTLE) || (state == DRAIN) || (state == BLANK);
      tmo_hit  = waiting && (tmo_cnt == TMO_MAX);
      boundary = frame_start || tmo_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= LOAD;
         pending      <= MODE_BITS'(DEFAULT_MODE);
         mode         <= MODE_BITS'(DEFAULT_MODE);
         mode_load    <= 1'b0;
         video_enable <= 1'b0;
         locked       <= 1'b0;
         req_ready    <= 1'b0;
         timeout_err  <= 1'b0;
         frame_cnt    <= 8'd0;
         tmo_cnt      <= '0;
      end else begin
         mode_load <= 1'b0;

         // Every state entry coincides with a boundary or a non-waiting state,
         // so the counter is already zero on entry without extra logic.
         if (waiting) begin
            if (tmo_hit && !frame_start)
               timeout_err <= 1'b1;
            if (boundary)
               tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
               tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end

         case (state)
            LOAD: begin
               // Coming from BLANK the pulse was issued on entry; after reset it is issued here.
               if (!mode_load) begin
                  mode_load <= 1'b1;
                  mode      <= pending;
               end
               frame_cnt <= 8'd0;
               state     <= SETTLE;
            end
            SETTLE: begin
               if (boundary) begin
                  if (frame_cnt == SETTLE_LAST) begin
                     frame_cnt    <= 8'd0;
                     state        <= RUN;
                     video_enable <= 1'b1;
                     locked       <= 1'b1;
                     req_ready    <= 1'b1;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            RUN: begin
               if (req_valid && req_ready && (req_mode != mode)) begin
                  pending     <= req_mode;
                  timeout_err <= 1'b0;
                  frame_cnt   <= 8'd0;
                  state       <= DRAIN;
                  locked      <= 1'b0;
                  req_ready   <= 1'b0;
               end
            end
            DRAIN: begin
               if (boundary) begin
                  frame_cnt    <= 8'd0;
                  state        <= BLANK;
                  video_enable <= 1'b0;
               end
            end
            BLANK: begin
               if (boundary) begin
                  if (frame_cnt == BLANK_LAST) begin
                     frame_cnt <= 8'd0;
                     state     <= LOAD;
                     mode_load <= 1'b1;
                     mode      <= pending;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_mode_switcher.sv
// tb/tb_video_mode_switcher.sv - self-checking bench for video_mode_switcher
// Loads are scoreboarded; per-scenario tasks check the frame-relative timing.

module tb_video_mode_switcher;

   localparam int FS_PERIOD = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_mode = 3'd0;
   logic       req_ready;
   logic       frame_start = 1'b0;
   logic [2:0] mode;
   logic       mode_load;
   logic       video_enable;
   logic       locked;
   logic       timeout_err;

   int         n_vec = 0;
   int         n_err = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_mode = 3'd0;
   logic [2:0] sb_exp;
   logic [2:0] prev_mode = 3'd0;
   logic       prev_load = 1'b0;
   bit         fs_en = 1'b0;
   int         fs_cnt = 0;

   video_mode_switcher #(
      .MODE_BITS(3), .DEFAULT_MODE(0), .BLANK_FRAMES(2),
      .SETTLE_FRAMES(4), .TIMEOUT_CYCLES(300)
   ) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_mode(req_mode),
      .req_ready(req_ready), .frame_start(frame_start), .mode(mode),
      .mode_load(mode_load), .video_enable(video_enable), .locked(locked),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!fs_en) begin
         frame_start = 1'b0;
         fs_cnt = 0;
      end else if (fs_cnt == FS_PERIOD - 1) begin
         frame_start = 1'b1;
         fs_cnt = 0;
      end else begin
         frame_start = 1'b0;
         fs_cnt = fs_cnt + 1;
      end
   end

   // Scoreboard: every mode_load pops the mode the bench expects next.
   always begin
      @(posedge clock);
      #1;
      if (mode_load) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_load: unexpected mode_load, mode=%0d, required no load", mode);
         end else begin
            sb_exp = exp_q.pop_front();
            if (mode !== sb_exp) begin
               n_err++;
               $display("FAIL sb_mode: mode=%0d at mode_load, required %0d", mode, sb_exp);
            end
         end
         n_vec++;
         if (prev_load) begin
            n_err++;
            $display("FAIL load_width: mode_load=1 on consecutive cycles, required 1-cycle pulse");
         end
      end
      if (!reset) begin
         n_vec++;
         if (mode !== prev_mode && !mode_load) begin
            n_err++;
            $display("FAIL mode_stable: mode %0d -> %0d without mode_load", prev_mode, mode);
         end
      end
      prev_mode = mode;
      prev_load = mode_load;
   end

   task automatic issue(input logic [2:0] m, output bit ok);
      logic rdy;
      ok = 1'b0;
      @(negedge clock);
      req_valid = 1'b1;
      req_mode  = m;
      for (int i = 0; i < 2000; i++) begin
         rdy = req_ready;
         @(posedge clock);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL accept: request mode=%0d not accepted, required acceptance", m);
      end else if (m != exp_mode) begin
         exp_q.push_back(m);
         exp_mode = m;
      end
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   // Pulse counts (after the call) at which video_enable is low, mode_load fires, locked rises.
   task automatic track(input int max_cyc, output int p_ve, output int p_load,
                        output int p_lock, output int c_load);
      int pulses;
      pulses = 0;
      p_ve = -1; p_load = -1; p_lock = -1; c_load = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clock);
         #1;
         if (frame_start) pulses++;
         if (p_ve < 0 && !video_enable) p_ve = pulses;
         if (p_load < 0 && mode_load) begin
            p_load = pulses;
            c_load = c;
         end
         if (p_load >= 0 && locked) begin
            p_lock = pulses;
            break;
         end
      end
   endtask

   task automatic check_change(input int pv, input int pl, input int pk, input logic [2:0] m);
      n_vec++;
      if (pv !== 1) begin n_err++; $display("FAIL ve_fall: video_enable fell at pulse %0d, required 1", pv); end
      n_vec++;
      if (pl !== 3) begin n_err++; $display("FAIL load_pulse: mode_load at pulse %0d, required 3", pl); end
      n_vec++;
      if (pk !== 7) begin n_err++; $display("FAIL relock: locked at pulse %0d, required 7", pk); end
      n_vec++;
      if ({mode, video_enable, req_ready} !== {m, 2'b11}) begin
         n_err++;
         $display("FAIL run_state: mode=%0d ve=%0b rdy=%0b, required mode=%0d ve=1 rdy=1",
                  mode, video_enable, req_ready, m);
      end
   endtask

   task automatic test_reset;
      int pv, pl, pk, cl;
      repeat (3) @(posedge clock);
      #1;
      n_vec++;
      if ({mode, mode_load, video_enable, locked, req_ready, timeout_err} !== 8'd0) begin
         n_err++;
         $display("FAIL reset_vals: mode=%0d load=%0b ve=%0b lock=%0b rdy=%0b terr=%0b, required all 0",
                  mode, mode_load, video_enable, locked, req_ready, timeout_err);
      end
      exp_q.push_back(3'd0);
      exp_mode = 3'd0;
      @(negedge clock);
      reset = 1'b0;
      fs_en = 1'b1;
      track(1000, pv, pl, pk, cl);
      n_vec++;
      if (cl !== 1) begin n_err++; $display("FAIL reset_load: mode_load %0d cycles after release, required 1", cl); end
      n_vec++;
      if (pk !== 4) begin n_err++; $display("FAIL reset_lock: locked at pulse %0d, required 4", pk); end
      n_vec++;
      if ({video_enable, req_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_run: ve=%0b rdy=%0b, required 1 1", video_enable, req_ready);
      end
   endtask

   task automatic test_mode_change;
      bit ok;
      int pv, pl, pk, cl;
      issue(3'd5, ok);
      n_vec++;
      if ({locked, req_ready, video_enable} !== 3'b001) begin
         n_err++;
         $display("FAIL accept_state: lock=%0b rdy=%0b ve=%0b, required 0 0 1", locked, req_ready, video_enable);
      end
      track(1000, pv, pl, pk, cl);
      check_change(pv, pl, pk, 3'd5);
   endtask

   task automatic test_same_mode;
      bit ok, bad;
      issue(3'd5, ok);
      n_vec++;
      if ({locked, req_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL same_accept: lock=%0b rdy=%0b, required 1 1", locked, req_ready);
      end
      bad = 1'b0;
      repeat (250) begin
         @(posedge clock);
         #1;
         if (!locked || mode_load) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin n_err++; $display("FAIL same_noop: locked dropped or mode_load seen, required locked=1 no load"); end
   endtask

   task automatic test_held_request;
      bit ok, bad, seen;
      int pv, pl, pk, cl;
      issue(3'd1, ok);
      for (int i = 0; i < 300; i++) begin
         @(posedge clock);
         #1;
         if (!video_enable) break;
      end
      @(negedge clock);
      req_valid = 1'b1;
      req_mode  = 3'd3;
      bad = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clock);
         #1;
         if (locked) begin
            seen = 1'b1;
            break;
         end
         if (req_ready) bad = 1'b1;
      end
      n_vec++;
      if (bad || !seen) begin n_err++; $display("FAIL held_ready: ready before RUN=%0b run seen=%0b, required 0 1", bad, seen); end
      n_vec++;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL held_run_ready: rdy=%0b, required 1", req_ready); end
      @(posedge clock);
      #1;
      n_vec++;
      if ({locked, req_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL held_accept: lock=%0b rdy=%0b, required 0 0", locked, req_ready);
      end
      exp_q.push_back(3'd3);
      exp_mode = 3'd3;
      @(negedge clock);
      req_valid = 1'b0;
      track(1000, pv, pl, pk, cl);
      n_vec++;
      if (pl !== 3) begin n_err++; $display("FAIL held_load: mode_load at pulse %0d, required 3", pl); end
      n_vec++;
      if (pk !== 7) begin n_err++; $display("FAIL held_lock: locked at pulse %0d, required 7", pk); end
   endtask

   task automatic test_timeout;
      bit ok, seen;
      int cl;
      int pv, pl, pk, c2;
      issue(3'd6, ok);
      for (int i = 0; i < 300; i++) begin
         @(posedge clock);
         #1;
         if (!video_enable) break;
      end
      @(negedge clock);
      fs_en = 1'b0;
      cl = -1;
      for (int c = 2; c <= 800; c++) begin
         @(posedge clock);
         #1;
         if (c == 290) begin
            n_vec++;
            if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: terr=%0b at cycle 290, required 0", timeout_err); end
         end
         if (c == 350) begin
            n_vec++;
            if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_set: terr=%0b at cycle 350, required 1", timeout_err); end
         end
         if (mode_load) begin
            cl = c;
            break;
         end
      end
      n_vec++;
      if (cl < 595 || cl > 612) begin n_err++; $display("FAIL tmo_load: mode_load %0d cycles into BLANK, required about 600", cl); end
      @(negedge clock);
      fs_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clock);
         #1;
         if (locked) begin
            seen = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!seen || timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_sticky: locked=%0b terr=%0b, required 1 1", seen, timeout_err);
      end
      issue(3'd2, ok);
      n_vec++;
      if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: terr=%0b after accept, required 0", timeout_err); end
      track(1000, pv, pl, pk, c2);
      check_change(pv, pl, pk, 3'd2);
   endtask

   task automatic test_reset_mid;
      bit ok, seen;
      int pv, pl, pk, cl;
      issue(3'd5, ok);
      seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock);
         #1;
         if (mode_load) begin
            seen = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!seen || mode !== 3'd5) begin n_err++; $display("FAIL mid_load: load=%0b mode=%0d, required 1 5", seen, mode); end
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_vec++;
      if ({mode, mode_load, video_enable, locked, req_ready} !== 7'd0) begin
         n_err++;
         $display("FAIL mid_reset: mode=%0d load=%0b ve=%0b lock=%0b rdy=%0b, required all 0",
                  mode, mode_load, video_enable, locked, req_ready);
      end
      exp_q.push_back(3'd0);
      exp_mode = 3'd0;
      @(negedge clock);
      reset = 1'b0;
      track(1000, pv, pl, pk, cl);
      n_vec++;
      if (cl !== 1) begin n_err++; $display("FAIL mid_reload: mode_load %0d cycles after release, required 1", cl); end
      n_vec++;
      if (pk !== 4 || mode !== 3'd0) begin n_err++; $display("FAIL mid_relock: lock pulse %0d mode=%0d, required 4 0", pk, mode); end
   endtask

   initial begin
      test_reset;
      test_mode_change;
      test_same_mode;
      test_held_request;
      test_timeout;
      test_reset_mid;
      repeat (3) @(posedge clock);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d expected loads never seen, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
